game_status_ctrl: RTL and testbench

Game-status bookkeeping stage sitting directly upstream of the top-level game FSM. It owns the M:SS countdown timer and the player hit-point counter, and feeds the FSM's LOSE condition (`time_up`, `hp_zero`). It also feeds the BCD digits for the 7-segment path and `curr_hp` for the LED path. It consumes the FSM's `state` plus single-cycle damage/heal event pulses.

---
 rtl/game_pkg.sv | 16 +
 rtl/bcd_countdown.sv | 60 ++++++
 rtl/game_status_ctrl.sv | 107 ++++++++++
 tb/tb_game_status_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings and widths for the game status path.
// The FSM state codes here must match the top-level game FSM.
package game_pkg;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_WAIT = 3'd1,
        ST_GAME = 3'd2,
        ST_WIN  = 3'd3,
        ST_LOSE = 3'd4
    } game_state_e;

    localparam int DIGIT_W = 4;
    localparam int HP_W    = 3;

endpackage

// File: rtl/bcd_countdown.sv
// M:SS BCD countdown; loads start digits, borrows across digits,
// and sticks at 0:00 instead of wrapping.
module bcd_countdown
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dec,
    input  logic [DIGIT_W-1:0] start_min,
    input  logic [DIGIT_W-1:0] start_sec_t,
    input  logic [DIGIT_W-1:0] start_sec_u,
    output logic [DIGIT_W-1:0] min,
    output logic [DIGIT_W-1:0] sec_t,
    output logic [DIGIT_W-1:0] sec_u,
    output logic               zero
);

    logic [DIGIT_W-1:0] min_q, min_d;
    logic [DIGIT_W-1:0] t_q, t_d;
    logic [DIGIT_W-1:0] u_q, u_d;

    assign zero = (min_q == '0) && (t_q == '0) && (u_q == '0);

    always_comb begin
        min_d = min_q;
        t_d   = t_q;
        u_d   = u_q;
        if (dec && !zero) begin
            if (u_q != '0) begin
                u_d = u_q - 1'b1;
            end else begin
                u_d = DIGIT_W'(9);
                if (t_q != '0) begin
                    t_d = t_q - 1'b1;
                end else begin
                    t_d   = DIGIT_W'(5);
                    min_d = min_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || load) begin
            min_q <= start_min;
            t_q   <= start_sec_t;
            u_q   <= start_sec_u;
        end else begin
            min_q <= min_d;
            t_q   <= t_d;
            u_q   <= u_d;
        end
    end

    assign min   = min_q;
    assign sec_t = t_q;
    assign sec_u = u_q;

endmodule

// File: rtl/game_status_ctrl.sv
// Countdown timer, hit points and invulnerability window for the game FSM.
// Everything reloads in INIT/WAIT and freezes in WIN/LOSE.
module game_status_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100_000_000,
    parameter int unsigned START_MIN     = 1,
    parameter int unsigned START_SEC_T   = 4,
    parameter int unsigned START_SEC_U   = 7,
    parameter int unsigned HP_START      = 3,
    parameter int unsigned HP_MAX        = 7,
    parameter int unsigned INVULN_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         state,
    input  logic               dmg_pulse,
    input  logic               heal_pulse,
    output logic [DIGIT_W-1:0] time_min,
    output logic [DIGIT_W-1:0] time_sec_t,
    output logic [DIGIT_W-1:0] time_sec_u,
    output logic               time_up,
    output logic [HP_W-1:0]    curr_hp,
    output logic               hp_zero,
    output logic               invuln
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int IW = (INVULN_CYCLES > 0) ? $clog2(INVULN_CYCLES + 1) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

    logic            game, reload;
    logic [PW-1:0]   pre_q, pre_d;
    logic [HP_W-1:0] hp_q, hp_d;
    logic [IW-1:0]   inv_q, inv_d;
    logic            dec, accept, heal, zero;

    // Unknown state codes fall into the reload branch, same as INIT.
    always_comb begin
        game   = 1'b0;
        reload = 1'b0;
        case (state)
            ST_GAME:         game   = 1'b1;
            ST_WIN, ST_LOSE: ;
            default:         reload = 1'b1;
        endcase
    end

    assign dec    = game && (pre_q == PRE_LAST);
    assign accept = game && dmg_pulse && (inv_q == '0) && (hp_q != '0);
    assign heal   = game && heal_pulse;

    always_comb begin
        pre_d = pre_q;
        hp_d  = hp_q;
        inv_d = inv_q;
        if (reload) begin
            pre_d = '0;
            hp_d  = HP_W'(HP_START);
            inv_d = '0;
        end else if (game) begin
            pre_d = dec ? '0 : pre_q + 1'b1;
            if (accept && !heal) begin
                hp_d = hp_q - 1'b1;
            end else if (!accept && heal && (hp_q < HP_W'(HP_MAX))) begin
                hp_d = hp_q + 1'b1;
            end
            if (accept) begin
                inv_d = IW'(INVULN_CYCLES);
            end else if (inv_q != '0) begin
                inv_d = inv_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            hp_q  <= HP_W'(HP_START);
            inv_q <= '0;
        end else begin
            pre_q <= pre_d;
            hp_q  <= hp_d;
            inv_q <= inv_d;
        end
    end

    bcd_countdown u_bcd (
        .clk         (clk),
        .rst         (rst),
        .load        (reload),
        .dec         (dec),
        .start_min   (DIGIT_W'(START_MIN)),
        .start_sec_t (DIGIT_W'(START_SEC_T)),
        .start_sec_u (DIGIT_W'(START_SEC_U)),
        .min         (time_min),
        .sec_t       (time_sec_t),
        .sec_u       (time_sec_u),
        .zero        (zero)
    );

    assign time_up = game && zero;
    assign curr_hp = hp_q;
    assign hp_zero = (hp_q == '0);
    assign invuln  = (inv_q != '0);

endmodule

// File: tb/tb_game_status_ctrl.sv
// Randomized bench for game_status_ctrl against a seconds-based model.
// A second instance starts at 0:01 to exercise the 0:00 stick.
module tb_game_status_ctrl;

    localparam int TPS = 4;
    localparam int INV = 3;
    localparam int HPS = 3;
    localparam int HPM = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state;
    logic       dmg_pulse, heal_pulse;

    logic [3:0] a_min, a_t, a_u, b_min, b_t, b_u;
    logic       a_tu, a_hz, a_inv, b_tu, b_hz, b_inv;
    logic [2:0] a_hp, b_hp;

    game_status_ctrl #(
        .TICKS_PER_SEC (TPS),
        .INVULN_CYCLES (INV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .dmg_pulse  (dmg_pulse),
        .heal_pulse (heal_pulse),
        .time_min   (a_min),
        .time_sec_t (a_t),
        .time_sec_u (a_u),
        .time_up    (a_tu),
        .curr_hp    (a_hp),
        .hp_zero    (a_hz),
        .invuln     (a_inv)
    );

    game_status_ctrl #(
        .TICKS_PER_SEC (TPS),
        .START_MIN     (0),
        .START_SEC_T   (0),
        .START_SEC_U   (1),
        .INVULN_CYCLES (INV)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .dmg_pulse  (dmg_pulse),
        .heal_pulse (heal_pulse),
        .time_min   (b_min),
        .time_sec_t (b_t),
        .time_sec_u (b_u),
        .time_up    (b_tu),
        .curr_hp    (b_hp),
        .hp_zero    (b_hz),
        .invuln     (b_inv)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Model: remaining time as plain seconds, hp and invuln as integers.
    int m_secs, m_secs2, m_pre, m_hp, m_inv;
    bit m_dec, m_acc;

    always @(posedge clk) begin
        if (rst || !(state inside {3'd2, 3'd3, 3'd4})) begin
            m_secs  = 60 + 47;
            m_secs2 = 1;
            m_pre   = 0;
            m_hp    = HPS;
            m_inv   = 0;
        end else if (state == 3'd2) begin
            m_dec = (m_pre == TPS - 1);
            m_pre = m_dec ? 0 : m_pre + 1;
            if (m_dec && m_secs > 0)  m_secs--;
            if (m_dec && m_secs2 > 0) m_secs2--;
            m_acc = dmg_pulse && m_inv == 0 && m_hp > 0;
            if (m_acc && !heal_pulse)                  m_hp--;
            else if (!m_acc && heal_pulse && m_hp < HPM) m_hp++;
            if (m_acc)           m_inv = INV;
            else if (m_inv > 0)  m_inv--;
        end
    end

    function automatic logic [11:0] bcd(input int s);
        return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    task automatic check_all();
        bit g;
        g = (state == 3'd2);
        chk("digits",   {a_min, a_t, a_u}, bcd(m_secs));
        chk("time_up",  a_tu, g && m_secs == 0);
        chk("hp",       a_hp, m_hp);
        chk("hp_zero",  a_hz, m_hp == 0);
        chk("invuln",   a_inv, m_inv != 0);
        chk("digits2",  {b_min, b_t, b_u}, bcd(m_secs2));
        chk("time_up2", b_tu, g && m_secs2 == 0);
        chk("hp2",      b_hp, m_hp);
        chk("invuln2",  b_inv, m_inv != 0);
    endtask

    task automatic cyc(input logic [2:0] st, input logic d, input logic h,
                       input logic r = 1'b0);
        rst        = r;
        state      = st;
        dmg_pulse  = d;
        heal_pulse = h;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; state = 3'd0; dmg_pulse = 1'b0; heal_pulse = 1'b0;
        cyc(3'd0, 0, 0, 1);
        cyc(3'd0, 0, 0, 1);
        cyc(3'd0, 0, 0, 0);
        chk("rst_digits", {a_min, a_t, a_u}, 12'h147);
        chk("rst_hp", a_hp, 3);
        chk("rst_tu", a_tu, 0);
        chk("rst_inv", a_inv, 0);
        chk("rst_hz", a_hz, 0);

        cyc(3'd1, 0, 0);
        for (int n = 1; n <= 192; n++) begin
            cyc(3'd2, 0, 0);
            if (n == 4) begin
                chk("first_dec", {a_min, a_t, a_u}, 12'h146);
                chk("d2_zero", {b_min, b_t, b_u}, 12'h000);
                chk("d2_tu", b_tu, 1);
            end
            if (n == 12) chk("d2_stick", {b_min, b_t, b_u, 3'b0, b_tu}, 16'h0001);
            if (n == 28) chk("at_140", {a_min, a_t, a_u}, 12'h140);
            if (n == 32) chk("at_139", {a_min, a_t, a_u}, 12'h139);
            if (n == 188) chk("at_100", {a_min, a_t, a_u}, 12'h100);
            if (n == 192) chk("at_059", {a_min, a_t, a_u}, 12'h059);
        end

        cyc(3'd1, 0, 0);
        cyc(3'd2, 1, 0);
        chk("hit_hp", a_hp, 2);
        chk("hit_inv", a_inv, 1);
        cyc(3'd2, 0, 0);
        cyc(3'd2, 1, 0);
        chk("inv_rej_hp", a_hp, 2);
        chk("inv_last", a_inv, 1);
        cyc(3'd2, 0, 0);
        chk("inv_end", a_inv, 0);
        cyc(3'd2, 1, 0);
        chk("hit2_hp", a_hp, 1);
        for (int i = 0; i < 8; i++) cyc(3'd2, 0, 1);
        chk("heal_sat", a_hp, 7);

        cyc(3'd1, 0, 0);
        cyc(3'd2, 1, 1);
        chk("both_hp", a_hp, 3);
        chk("both_inv", a_inv, 1);

        cyc(3'd1, 0, 0);
        for (int n = 1; n <= 96; n++) cyc(3'd2, n == 1 || n == 10, 0);
        chk("pre_win", {a_min, a_t, a_u, 1'b0, a_hp}, 16'h1231);
        for (int i = 0; i < 20; i++) cyc(3'd3, 1, 1);
        chk("frozen", {a_min, a_t, a_u, 1'b0, a_hp}, 16'h1231);
        cyc(3'd1, 0, 0);
        chk("reload", {a_min, a_t, a_u, 1'b0, a_hp}, 16'h1473);

        for (int blk = 0; blk < 150; blk++) begin
            int r;
            int len;
            logic [2:0] st;
            r = $urandom_range(0, 11);
            if (r <= 6)       st = 3'd2;
            else if (r == 7)  st = 3'd1;
            else if (r == 8)  st = 3'd3;
            else if (r == 9)  st = 3'd4;
            else if (r == 10) st = 3'd0;
            else              st = 3'($urandom_range(5, 7));
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++)
                cyc(st, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 199) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
